// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM access controller: one read or write per request, fixed-length access window.
// Latency: ack arrives WAIT_CYCLES+1 clocks after the accepted req cycle.
// Backpressure: none; requests seen while busy are dropped, so the requester must watch busy.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,   // legal range 1..15
    parameter int AW          = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    inout  wire  [15:0]   sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter preload; ACCESS ends on the cycle the counter reads zero.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        dq_en;

    // Data bus is only ever driven by us during a write (ACCESS plus one DONE hold cycle).
    assign sram_dq = dq_en ? wdata_q : 16'hzzzz;

    // Transaction FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dq_en     <= 1'b0;
            rdata     <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= ACCESS;
                        cnt       <= CNT_INIT;
                        we_q      <= we;
                        wdata_q   <= wdata;
                        dq_en     <= we;
                        busy      <= 1'b1;
                        sram_addr <= addr;
                        sram_ce_n <= 1'b0;
                        // oe_n and we_n are complementary, so never both low
                        sram_oe_n <= we;
                        sram_we_n <= ~we;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= DONE;
                        ack       <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        // Capture read data while oe_n is still low on the bus
                        if (!we_q) begin
                            rdata <= sram_dq;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ack       <= 1'b0;
                    busy      <= 1'b0;
                    sram_addr <= '0;
                    dq_en     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, sets SRAM access cycles per transaction; legal range 1..15.
REQ-002 Parameter AW, default 16, sets address width; data width is fixed at 16.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, 1: single-cycle transaction request pulse from the control FSM.
REQ-006 Port we, input, 1: 1 = write, 0 = read; qualified by req.
REQ-007 Port addr, input, AW: word address; qualified by req.
REQ-008 Port wdata, input, 16: write data; qualified by req.
REQ-009 Port rdata, output, 16: read data; valid in the ack cycle of a read.
REQ-010 Port ack, output, 1: one-cycle completion pulse.
REQ-011 Port busy, output, 1: high whenever not in IDLE.
REQ-012 Port sram_addr, output, AW: external SRAM address.
REQ-013 Port sram_dq, inout, 16: external SRAM data bus.
REQ-014 Ports sram_ce_n, sram_oe_n, sram_we_n, output, 1 each: active-low chip enable, output enable, write enable.

Function
REQ-015 The FSM shall have three states: IDLE, ACCESS, DONE.
REQ-016 In IDLE with req=1, the block shall latch we, addr, wdata, load the wait counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-017 req sampled in ACCESS or DONE shall be ignored with no effect on the latched transaction; the requester uses busy to avoid this.
REQ-018 ACCESS shall last exactly WAIT_CYCLES cycles; the counter decrements each cycle; ACCESS -> DONE when the counter is 0.
REQ-019 DONE shall last one cycle, assert ack=1, and return to IDLE; a req in the following IDLE cycle shall be accepted.
REQ-020 Latency from req cycle to ack cycle shall be WAIT_CYCLES+1 clocks for reads and writes.
REQ-021 sram_addr shall drive the latched address in ACCESS and DONE, and 0 in IDLE.
REQ-022 sram_ce_n shall be 0 in ACCESS only; otherwise 1.
REQ-023 Read: sram_oe_n=0 in ACCESS; sram_dq undriven (Z) in all states; on the last ACCESS cycle sram_dq shall be registered into rdata.
REQ-024 rdata shall hold its value until the next read completes; writes shall not modify rdata.
REQ-025 Write: sram_we_n=0 in ACCESS; sram_dq driven with latched wdata in ACCESS and DONE (one hold cycle after we_n rises); sram_oe_n=1.
REQ-026 sram_dq shall be Z in IDLE and during all read states; sram_oe_n and sram_we_n shall never both be 0.
REQ-027 ack shall be registered, high only in DONE; busy shall be 1 in ACCESS and DONE.

Reset
REQ-028 reset=1 at a rising edge shall force IDLE, clear the counter, rdata=0, ack=0, busy=0, sram_addr=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_dq=Z.
REQ-029 reset mid-transaction shall abort it with no ack; an aborted write may leave SRAM contents undefined at that address.
REQ-030 reset shall take priority over a simultaneous req.

Verification
REQ-031 Write then read, WAIT_CYCLES=2: req,we=1,addr=0x0010,wdata=0xBEEF at cycle 0 -> we_n low cycles 1-2, ack cycle 3; read addr 0x0010 -> oe_n low cycles 1-2, ack cycle 3, rdata=0xBEEF.
REQ-032 Back-to-back: new req in the IDLE cycle right after ack -> accepted; second ack exactly WAIT_CYCLES+2 cycles after the first.
REQ-033 Ignored request: req with addr=0x0020 during ACCESS of a read to 0x0010 -> sram_addr stays 0x0010, exactly one ack.
REQ-034 Reset mid-write: reset asserted in first ACCESS cycle -> next cycle IDLE, we_n=1, dq=Z, no ack ever for that request.
REQ-035 WAIT_CYCLES=1 and 15: read -> ack at cycle 2 and 16 respectively; rdata matches the SRAM model.
REQ-036 Bus contention check: over a random 1000-transaction stream, sram_dq never driven while sram_oe_n=0, and oe_n/we_n never simultaneously 0.
